// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: opcode constants, ALU/forwarding encodings and the decoded
// control bundle shared by the pipeline control slice.
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluSll   = 4'd2,
        AluSlt   = 4'd3,
        AluSltu  = 4'd4,
        AluXor   = 4'd5,
        AluSrl   = 4'd6,
        AluSra   = 4'd7,
        AluOr    = 4'd8,
        AluAnd   = 4'd9,
        AluPassB = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        SrcRegFile = 2'b00,
        SrcExMem   = 2'b01,
        SrcMemWb   = 2'b10
    } src_sel_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    imm_sel;
        logic    mem_re;
        logic    mem_we;
        logic    wb_we;
        logic    wb_to_reg;
        logic    use_rs1;
        logic    use_rs2;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '{
        alu_op:    AluAdd,
        imm_sel:   1'b0,
        mem_re:    1'b0,
        mem_we:    1'b0,
        wb_we:     1'b0,
        wb_to_reg: 1'b0,
        use_rs1:   1'b0,
        use_rs2:   1'b0
    };

    // funct3/funct7b5 to ALU op; SUB only exists in the register-register form.
    function automatic alu_op_e alu_from_funct(input logic [2:0] funct3,
                                               input logic       funct7b5,
                                               input logic       is_reg);
        case (funct3)
            3'b000:  return (is_reg && funct7b5) ? AluSub : AluAdd;
            3'b001:  return AluSll;
            3'b010:  return AluSlt;
            3'b011:  return AluSltu;
            3'b100:  return AluXor;
            3'b101:  return funct7b5 ? AluSra : AluSrl;
            3'b110:  return AluOr;
            default: return AluAnd;
        endcase
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: ID-stage instruction fields and branch redirect in, hazard
// signals and per-stage control out. master drives ID, slave is the controller.
interface pipe_ctrl_if #(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned ALU_CTRL_W = 4
);
    logic                  id_valid;
    logic [6:0]            id_opcode;
    logic [2:0]            id_funct3;
    logic                  id_funct7b5;
    logic [REG_AW-1:0]     id_rs1;
    logic [REG_AW-1:0]     id_rs2;
    logic [REG_AW-1:0]     id_rd;
    logic                  branch_taken;
    logic                  stall;
    logic                  flush;
    logic [ALU_CTRL_W-1:0] ex_alu_ctrl;
    logic [1:0]            ex_src1_sel;
    logic [1:0]            ex_src2_sel;
    logic                  ex_imm_sel;
    logic                  mem_re;
    logic                  mem_we;
    logic                  wb_we;
    logic                  wb_to_reg_sel;
    logic [REG_AW-1:0]     wb_rd;

    modport master (
        output id_valid, id_opcode, id_funct3, id_funct7b5, id_rs1, id_rs2, id_rd,
               branch_taken,
        input  stall, flush, ex_alu_ctrl, ex_src1_sel, ex_src2_sel, ex_imm_sel,
               mem_re, mem_we, wb_we, wb_to_reg_sel, wb_rd
    );

    modport slave (
        input  id_valid, id_opcode, id_funct3, id_funct7b5, id_rs1, id_rs2, id_rd,
               branch_taken,
        output stall, flush, ex_alu_ctrl, ex_src1_sel, ex_src2_sel, ex_imm_sel,
               mem_re, mem_we, wb_we, wb_to_reg_sel, wb_rd
    );
endinterface

// File: rtl/pipe_ctrl_decode.sv
// pipe_ctrl_decode: purely combinational opcode/funct decode into a control
// bundle. Unknown opcodes decode as a bubble.
module pipe_ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic         funct7b5,
    output ctrl_bundle_t ctrl
);

    // Per-format enables and source usage.
    always_comb begin
        ctrl = CTRL_BUBBLE;
        case (opcode)
            OP_R: begin
                ctrl.alu_op  = alu_from_funct(funct3, funct7b5, 1'b1);
                ctrl.wb_we   = 1'b1;
                ctrl.use_rs1 = 1'b1;
                ctrl.use_rs2 = 1'b1;
            end
            OP_IMM: begin
                ctrl.alu_op  = alu_from_funct(funct3, funct7b5, 1'b0);
                ctrl.imm_sel = 1'b1;
                ctrl.wb_we   = 1'b1;
                ctrl.use_rs1 = 1'b1;
            end
            OP_LOAD: begin
                ctrl.imm_sel   = 1'b1;
                ctrl.mem_re    = 1'b1;
                ctrl.wb_we     = 1'b1;
                ctrl.wb_to_reg = 1'b1;
                ctrl.use_rs1   = 1'b1;
            end
            OP_STORE: begin
                ctrl.imm_sel = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.use_rs1 = 1'b1;
                ctrl.use_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.alu_op  = AluSub;
                ctrl.use_rs1 = 1'b1;
                ctrl.use_rs2 = 1'b1;
            end
            OP_LUI: begin
                ctrl.alu_op  = AluPassB;
                ctrl.imm_sel = 1'b1;
                ctrl.wb_we   = 1'b1;
            end
            OP_AUIPC, OP_JAL: begin
                ctrl.imm_sel = 1'b1;
                ctrl.wb_we   = 1'b1;
            end
            OP_JALR: begin
                ctrl.imm_sel = 1'b1;
                ctrl.wb_we   = 1'b1;
                ctrl.use_rs1 = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: in-order pipeline control. Decodes the ID instruction, detects
// hazards, and carries control through ID/EX, EX/MEM and MEM/WB.
// Optional feature macro PIPE_CTRL_FWD_EN: when defined, operands are forwarded
// from EX/MEM and MEM/WB and only load-use stalls; when undefined, selects stay
// at the register file and any RAW on an in-flight producer stalls.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned ALU_CTRL_W = 4
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);

    ctrl_bundle_t dec_ctrl;
    ctrl_bundle_t id_ctrl;
    logic         id_wr;
    logic         rs1_ex_hit, rs2_ex_hit, rs1_mem_hit, rs2_mem_hit;
    logic         hazard;
    logic         kill_id;
    src_sel_e     src1_d, src2_d;

    // ID/EX
    alu_op_e           ex_alu_q;
    logic              ex_imm_q;
    src_sel_e          ex_src1_q, ex_src2_q;
    logic              ex_mem_re_q, ex_mem_we_q, ex_wb_we_q, ex_wb_to_reg_q;
    logic [REG_AW-1:0] ex_rd_q;
    // EX/MEM
    logic              mem_re_q, mem_we_q, mem_wb_we_q, mem_wb_to_reg_q;
    logic [REG_AW-1:0] mem_rd_q;
    // MEM/WB
    logic              wb_we_q, wb_to_reg_q;
    logic [REG_AW-1:0] wb_rd_q;

    pipe_ctrl_decode u_decode (
        .opcode   (bus.id_opcode),
        .funct3   (bus.id_funct3),
        .funct7b5 (bus.id_funct7b5),
        .ctrl     (dec_ctrl)
    );

    // Match used ID sources against in-flight destinations; pick stall or forward.
    always_comb begin
        id_ctrl     = bus.id_valid ? dec_ctrl : CTRL_BUBBLE;
        id_wr       = id_ctrl.wb_we && (bus.id_rd != '0);
        rs1_ex_hit  = id_ctrl.use_rs1 && ex_wb_we_q && (ex_rd_q != '0) &&
                      (bus.id_rs1 == ex_rd_q);
        rs2_ex_hit  = id_ctrl.use_rs2 && ex_wb_we_q && (ex_rd_q != '0) &&
                      (bus.id_rs2 == ex_rd_q);
        rs1_mem_hit = id_ctrl.use_rs1 && mem_wb_we_q && (mem_rd_q != '0) &&
                      (bus.id_rs1 == mem_rd_q);
        rs2_mem_hit = id_ctrl.use_rs2 && mem_wb_we_q && (mem_rd_q != '0) &&
                      (bus.id_rs2 == mem_rd_q);
`ifdef PIPE_CTRL_FWD_EN
        // Today's EX becomes EX/MEM and today's MEM becomes MEM/WB next cycle.
        hazard = ex_mem_re_q && (rs1_ex_hit || rs2_ex_hit);
        src1_d = rs1_ex_hit ? SrcExMem : (rs1_mem_hit ? SrcMemWb : SrcRegFile);
        src2_d = rs2_ex_hit ? SrcExMem : (rs2_mem_hit ? SrcMemWb : SrcRegFile);
`else
        hazard = rs1_ex_hit || rs2_ex_hit || rs1_mem_hit || rs2_mem_hit;
        src1_d = SrcRegFile;
        src2_d = SrcRegFile;
`endif
        kill_id = hazard || bus.branch_taken;
    end

    // ID/EX: take the decoded instruction, or a bubble on stall/flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || kill_id) begin
            ex_alu_q       <= AluAdd;
            ex_imm_q       <= 1'b0;
            ex_src1_q      <= SrcRegFile;
            ex_src2_q      <= SrcRegFile;
            ex_mem_re_q    <= 1'b0;
            ex_mem_we_q    <= 1'b0;
            ex_wb_we_q     <= 1'b0;
            ex_wb_to_reg_q <= 1'b0;
            ex_rd_q        <= '0;
        end else begin
            ex_alu_q       <= id_ctrl.alu_op;
            ex_imm_q       <= id_ctrl.imm_sel;
            ex_src1_q      <= src1_d;
            ex_src2_q      <= src2_d;
            ex_mem_re_q    <= id_ctrl.mem_re;
            ex_mem_we_q    <= id_ctrl.mem_we;
            ex_wb_we_q     <= id_wr;
            ex_wb_to_reg_q <= id_ctrl.wb_to_reg;
            ex_rd_q        <= id_wr ? bus.id_rd : '0;
        end
    end

    // EX/MEM and MEM/WB always advance; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_re_q        <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_wb_we_q     <= 1'b0;
            mem_wb_to_reg_q <= 1'b0;
            mem_rd_q        <= '0;
            wb_we_q         <= 1'b0;
            wb_to_reg_q     <= 1'b0;
            wb_rd_q         <= '0;
        end else begin
            mem_re_q        <= ex_mem_re_q;
            mem_we_q        <= ex_mem_we_q;
            mem_wb_we_q     <= ex_wb_we_q;
            mem_wb_to_reg_q <= ex_wb_to_reg_q;
            mem_rd_q        <= ex_rd_q;
            wb_we_q         <= mem_wb_we_q;
            wb_to_reg_q     <= mem_wb_to_reg_q;
            wb_rd_q         <= mem_rd_q;
        end
    end

    // A taken branch overrides a stall; both stay low in reset.
    assign bus.stall         = hazard && !bus.branch_taken && !rst;
    assign bus.flush         = bus.branch_taken && !rst;
    assign bus.ex_alu_ctrl   = ALU_CTRL_W'(ex_alu_q);
    assign bus.ex_src1_sel   = ex_src1_q;
    assign bus.ex_src2_sel   = ex_src2_q;
    assign bus.ex_imm_sel    = ex_imm_q;
    assign bus.mem_re        = mem_re_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.wb_we         = wb_we_q;
    assign bus.wb_to_reg_sel = wb_to_reg_q;
    assign bus.wb_rd         = wb_rd_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed sequence; each issued step pushes the expected ID/EX
// content to a scoreboard queue whose entries are checked as they pass EX, MEM, WB.
module tb_pipe_ctrl;

    localparam int OP_R   = 'h33;
    localparam int OP_I   = 'h13;
    localparam int OP_LD  = 'h03;
    localparam int OP_ST  = 'h23;
    localparam int OP_BR  = 'h63;
    localparam int OP_LUI = 'h37;
    localparam int OP_BAD = 'h7f;

    typedef struct packed {
        logic [3:0] alu;
        logic       imm;
        logic [1:0] s1;
        logic [1:0] s2;
        logic       mre;
        logic       mwe;
        logic       wwe;
        logic       wtr;
        logic [4:0] rd;
    } exp_t;

    localparam exp_t BUB = '0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    pipe_ctrl_if #(.REG_AW(5), .ALU_CTRL_W(4)) bus ();

    pipe_ctrl #(.REG_AW(5), .ALU_CTRL_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int alu, input int imm, input int s1, input int s2,
                                input int mre, input int mwe, input int wwe, input int wtr,
                                input int rd);
        exp_t e;
        e.alu = 4'(alu);
        e.imm = 1'(imm);
        e.s1  = 2'(s1);
        e.s2  = 2'(s2);
        e.mre = 1'(mre);
        e.mwe = 1'(mwe);
        e.wwe = 1'(wwe);
        e.wtr = 1'(wtr);
        e.rd  = 5'(rd);
        return e;
    endfunction

    task automatic drive(input int v, input int op, input int f3, input int f7,
                         input int rs1, input int rs2, input int rd, input int br);
        bus.id_valid     = 1'(v);
        bus.id_opcode    = 7'(op);
        bus.id_funct3    = 3'(f3);
        bus.id_funct7b5  = 1'(f7);
        bus.id_rs1       = 5'(rs1);
        bus.id_rs2       = 5'(rs2);
        bus.id_rd        = 5'(rd);
        bus.branch_taken = 1'(br);
    endtask

    // Called at posedge+1: drive, check stall/flush, clock, then check all stages.
    task automatic issue(input string tag, input int v, input int op, input int f3,
                         input int f7, input int rs1, input int rs2, input int rd,
                         input int br, input int exp_stall, input int exp_flush,
                         input exp_t e);
        drive(v, op, f3, f7, rs1, rs2, rd, br);
        #1;
        chk({tag, " stall"}, 32'(bus.stall), 32'(exp_stall));
        chk({tag, " flush"}, 32'(bus.flush), 32'(exp_flush));
        @(posedge clk);
        #1;
        sb.push_back(e);
        // sb[0] now sits in MEM/WB, sb[1] in EX/MEM, sb[2] in ID/EX
        chk({tag, " ex_alu_ctrl"}, 32'(bus.ex_alu_ctrl), 32'(sb[2].alu));
        chk({tag, " ex_imm_sel"}, 32'(bus.ex_imm_sel), 32'(sb[2].imm));
        chk({tag, " ex_src1_sel"}, 32'(bus.ex_src1_sel), 32'(sb[2].s1));
        chk({tag, " ex_src2_sel"}, 32'(bus.ex_src2_sel), 32'(sb[2].s2));
        chk({tag, " mem_re"}, 32'(bus.mem_re), 32'(sb[1].mre));
        chk({tag, " mem_we"}, 32'(bus.mem_we), 32'(sb[1].mwe));
        chk({tag, " wb_we"}, 32'(bus.wb_we), 32'(sb[0].wwe));
        chk({tag, " wb_to_reg_sel"}, 32'(bus.wb_to_reg_sel), 32'(sb[0].wtr));
        chk({tag, " wb_rd"}, 32'(bus.wb_rd), 32'(sb[0].rd));
        void'(sb.pop_front());
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " stall"}, 32'(bus.stall), 0);
        chk({tag, " flush"}, 32'(bus.flush), 0);
        chk({tag, " ex_alu_ctrl"}, 32'(bus.ex_alu_ctrl), 0);
        chk({tag, " ex_imm_sel"}, 32'(bus.ex_imm_sel), 0);
        chk({tag, " ex_src1_sel"}, 32'(bus.ex_src1_sel), 0);
        chk({tag, " ex_src2_sel"}, 32'(bus.ex_src2_sel), 0);
        chk({tag, " mem_re"}, 32'(bus.mem_re), 0);
        chk({tag, " mem_we"}, 32'(bus.mem_we), 0);
        chk({tag, " wb_we"}, 32'(bus.wb_we), 0);
        chk({tag, " wb_to_reg_sel"}, 32'(bus.wb_to_reg_sel), 0);
        chk({tag, " wb_rd"}, 32'(bus.wb_rd), 0);
    endtask

    task automatic restart_sb();
        sb.delete();
        sb.push_back(BUB);
        sb.push_back(BUB);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset with a valid instruction and a redirect presented: all must stay quiet.
        drive(1, OP_R, 0, 0, 1, 2, 3, 1);
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        restart_sb();

        // add x3,x1,x2 ; sub x4,x3,x1
        issue("add_x3", 1, OP_R, 0, 0, 1, 2, 3, 0, 0, 0, mk(0, 1'b0, 0, 0, 0, 0, 1, 0, 3));
`ifdef PIPE_CTRL_FWD_EN
        issue("sub_fwd", 1, OP_R, 0, 1, 3, 1, 4, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 1, 0, 4));
`else
        issue("sub_st1", 1, OP_R, 0, 1, 3, 1, 4, 0, 1, 0, BUB);
        issue("sub_st2", 1, OP_R, 0, 1, 3, 1, 4, 0, 1, 0, BUB);
        issue("sub_go", 1, OP_R, 0, 1, 3, 1, 4, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 1, 0, 4));
`endif

        // lw x5,0(x1) (rs2 field = x4 is not a source) ; add x6,x5,x2
        issue("lw_x5", 1, OP_LD, 2, 0, 1, 4, 5, 0, 0, 0, mk(0, 1, 0, 0, 1, 0, 1, 1, 5));
        issue("ld_use", 1, OP_R, 0, 0, 5, 2, 6, 0, 1, 0, BUB);
`ifdef PIPE_CTRL_FWD_EN
        issue("ld_fwd", 1, OP_R, 0, 0, 5, 2, 6, 0, 0, 0, mk(0, 0, 2, 0, 0, 0, 1, 0, 6));
`else
        issue("ld_st2", 1, OP_R, 0, 0, 5, 2, 6, 0, 1, 0, BUB);
        issue("ld_go", 1, OP_R, 0, 0, 5, 2, 6, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 6));
`endif

        // Load in EX, dependent in ID, branch taken: flush wins over stall
        issue("lw_x5b", 1, OP_LD, 2, 0, 1, 0, 5, 0, 0, 0, mk(0, 1, 0, 0, 1, 0, 1, 1, 5));
        issue("br_flush", 1, OP_R, 0, 0, 5, 2, 6, 1, 0, 1, BUB);
        issue("invalid", 0, OP_R, 0, 0, 5, 5, 6, 0, 0, 0, BUB);

        // addi x0,x1,5 ; add x7,x0,x0
        issue("addi_x0", 1, OP_I, 0, 0, 1, 5, 0, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        issue("add_x7", 1, OP_R, 0, 0, 0, 0, 7, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 7));

        // Undecodable opcode: bubble, and its fields (x7) create no hazard
        issue("bad_op", 1, OP_BAD, 0, 0, 7, 7, 9, 0, 0, 0, BUB);

        // ALU op coverage on independent sources
        issue("r_sra", 1, OP_R, 5, 1, 1, 2, 10, 0, 0, 0, mk(7, 0, 0, 0, 0, 0, 1, 0, 10));
        issue("i_srai", 1, OP_I, 5, 1, 1, 2, 11, 0, 0, 0, mk(7, 1, 0, 0, 0, 0, 1, 0, 11));
        issue("i_addi7", 1, OP_I, 0, 1, 1, 2, 12, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 1, 0, 12));
        issue("r_and", 1, OP_R, 7, 0, 1, 2, 13, 0, 0, 0, mk(9, 0, 0, 0, 0, 0, 1, 0, 13));
        issue("r_or", 1, OP_R, 6, 0, 1, 2, 14, 0, 0, 0, mk(8, 0, 0, 0, 0, 0, 1, 0, 14));
        issue("r_xor", 1, OP_R, 4, 0, 1, 2, 15, 0, 0, 0, mk(5, 0, 0, 0, 0, 0, 1, 0, 15));
        issue("i_sltu", 1, OP_I, 3, 0, 1, 2, 16, 0, 0, 0, mk(4, 1, 0, 0, 0, 0, 1, 0, 16));
        issue("r_slt", 1, OP_R, 2, 0, 1, 2, 17, 0, 0, 0, mk(3, 0, 0, 0, 0, 0, 1, 0, 17));
        issue("r_sll", 1, OP_R, 1, 0, 1, 2, 18, 0, 0, 0, mk(2, 0, 0, 0, 0, 0, 1, 0, 18));
        issue("i_srl", 1, OP_I, 5, 0, 1, 2, 19, 0, 0, 0, mk(6, 1, 0, 0, 0, 0, 1, 0, 19));
        // LUI rs1 field equals the EX destination but LUI reads no register
        issue("lui", 1, OP_LUI, 0, 0, 19, 19, 20, 0, 0, 0, mk(10, 1, 0, 0, 0, 0, 1, 0, 20));
        issue("store", 1, OP_ST, 2, 0, 1, 2, 0, 0, 0, 0, mk(0, 1, 0, 0, 0, 1, 0, 0, 0));
        issue("branch", 1, OP_BR, 0, 0, 1, 2, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            issue("drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, BUB);
        end

        // Reset pulse mid-cycle with work in flight and a redirect on the input
        issue("lw_x21", 1, OP_LD, 2, 0, 1, 0, 21, 0, 0, 0, mk(0, 1, 0, 0, 1, 0, 1, 1, 21));
        issue("add_x22", 1, OP_R, 0, 0, 1, 2, 22, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 22));
        drive(1, OP_R, 0, 0, 22, 21, 23, 1);
        #1;
        rst = 1'b1;
        #1;
        check_reset("mid_reset");
        @(posedge clk);
        #1;
        check_reset("mid_reset_hold");
        rst = 1'b0;
        restart_sb();
        for (int i = 0; i < 3; i++) begin
            issue("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, BUB);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-002 SHALL have parameter ALU_CTRL_W, default 4, meaning ALU control width (>=4).
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updated on posedge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port id_valid, input, 1 bit: ID-stage instruction valid.
REQ-006 SHALL have port id_opcode, input, 7 bits: ID opcode.
REQ-007 SHALL have port id_funct3, input, 3 bits: ID funct3.
REQ-008 SHALL have port id_funct7b5, input, 1 bit: ID instr[30].
REQ-009 SHALL have ports id_rs1, id_rs2 and id_rd, input, REG_AW bits each: ID register addresses.
REQ-010 SHALL have port branch_taken, input, 1 bit: EX-stage redirect.
REQ-011 SHALL have port stall, output, 1 bit: hold PC and IF/ID.
REQ-012 SHALL have port flush, output, 1 bit: kill IF/ID.
REQ-013 SHALL have port ex_alu_ctrl, output, ALU_CTRL_W bits: EX ALU operation.
REQ-014 SHALL have ports ex_src1_sel and ex_src2_sel, output, 2 bits each: 00 regfile, 01 EX/MEM forward, 10 MEM/WB forward.
REQ-015 SHALL have port ex_imm_sel, output, 1 bit: ALU operand B is the immediate.
REQ-016 SHALL have ports mem_re, mem_we, wb_we and wb_to_reg_sel, output, 1 bit each: MEM/WB stage controls.
REQ-017 SHALL have port wb_rd, output, REG_AW bits: writeback address.

Function
REQ-018 SHALL decode R, I-ALU, LOAD, STORE, BRANCH, LUI, AUIPC, JAL and JALR.
REQ-019 SHALL decode any other opcode, or id_valid=0, as a bubble: all enables 0, alu ADD.
REQ-020 SHALL map ALU ops: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASS_B 10.
REQ-021 SHALL select SUB and SRA via funct7b5 (SUB R-type only).
REQ-022 SHALL decode LOAD, STORE and JALR as ADD, BRANCH as SUB, and LUI as PASS_B.
REQ-023 SHALL register control through ID/EX, EX/MEM and MEM/WB, so EX outputs appear 1 cycle after ID sampling and WB outputs 3 cycles after.
REQ-024 SHALL treat a write to rd=0 as a write with wb_we forced 0.
REQ-025 SHALL assert stall combinationally for load-use: EX is LOAD, ex_rd!=0, and ex_rd equals a used ID source.
REQ-026 SHALL, while stall is high, load a bubble into ID/EX and advance EX/MEM and MEM/WB normally.
REQ-027 SHALL, on branch_taken, assert flush and load a bubble into ID/EX.
REQ-028 SHALL give branch_taken priority over stall; stall SHALL be 0 in that cycle.
REQ-029 SHALL compute forwarding selects for ID sources when ID/EX loads: EX/MEM match beats MEM/WB match, and x0 is never forwarded.
REQ-030 SHALL treat a source as used only if its format reads it: rs2 for R, STORE and BRANCH; rs1 for all except LUI, AUIPC and JAL.

Reset
REQ-031 SHALL, while rst=1, clear all pipeline control registers to bubble: alu_ctrl 0, selects 00, ex_imm_sel 0, mem_re/mem_we/wb_we/wb_to_reg_sel 0, wb_rd 0.
REQ-032 SHALL hold stall and flush at 0 during reset.
REQ-033 SHALL discard in-flight instructions on reset mid-operation.

Configuration
REQ-034 SHALL implement forwarding as in REQ-029 when PIPE_CTRL_FWD_EN is defined.
REQ-035 SHALL, without PIPE_CTRL_FWD_EN, tie both selects to 00 and stall on any used-source match with a valid EX or MEM destination (rd!=0), including non-load producers.

Structure
REQ-036 SHALL place opcode constants, alu_op_e, src_sel_e and the ctrl_bundle_t struct in package pipe_ctrl_pkg.
REQ-037 SHALL use a combinational sub-module pipe_ctrl_decode (opcode, funct3, funct7b5 -> ctrl_bundle_t); hazard and pipeline logic SHALL stay in pipe_ctrl.

Verification
REQ-038 SHALL cover: add x3,x1,x2 then sub x4,x3,x1 -> cycle 2 ex_alu_ctrl=1, ex_src1_sel=01 (FWD_EN) or stall=1 for 2 cycles (no FWD_EN).
REQ-039 SHALL cover: lw x5,0(x1) then add x6,x5,x2 -> stall=1 exactly 1 cycle, bubble in EX, then ex_src1_sel=10.
REQ-040 SHALL cover: lw x5 followed by a taken branch in EX with a dependent instruction in ID -> flush=1, stall=0.
REQ-041 SHALL cover: addi x0,x1,5 then add x7,x0,x0 -> wb_we=0 and selects 00.
REQ-042 SHALL cover: opcode 7'b1111111 -> bubble; rst pulse mid-stream -> all outputs at reset values in the same cycle.
